// File: rtl/mem_req_queue.sv
// In-order request FIFO between the datapath and a tagged memory bus.
// Retries the head until memory accepts it and turns returned tags into load/store completion pulses.
module mem_req_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            proc2q_command,
  input  logic [ADDR_WIDTH-1:0] proc2q_address,
  input  logic [DATA_WIDTH-1:0] proc2q_data,
  output logic                  q2proc_ready,
  output logic [1:0]            q2mem_command,
  output logic [ADDR_WIDTH-1:0] q2mem_address,
  output logic [DATA_WIDTH-1:0] q2mem_data,
  input  logic [3:0]            mem2q_response,
  input  logic [3:0]            mem2q_tag,
  input  logic [DATA_WIDTH-1:0] mem2q_data,
  output logic                  q2proc_ld_valid,
  output logic [DATA_WIDTH-1:0] q2proc_ld_data,
  output logic                  q2proc_st_done,
  output logic                  q2proc_error
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef struct packed {
    logic [1:0]            cmd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                fifo_q [DEPTH];
  entry_t                wr_entry, head;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [3:0]            outstanding_q, outstanding_d;
  logic [15:0]           valid_q, valid_d, is_load_q, is_load_d;
  logic                  ld_valid_q, ld_valid_d, st_done_q, st_done_d, error_q, error_d;
  logic [DATA_WIDTH-1:0] ld_data_q, ld_data_d;
  logic                  enq, issue, accept, comp_hit, comp_bad, acc_dup;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    head     = fifo_q[rd_ptr_q];
    enq      = (proc2q_command == CMD_LOAD || proc2q_command == CMD_STORE) &&
               (count_q != CNT_W'(DEPTH));
    issue    = (count_q != '0) && (outstanding_q < 4'(MAX_OUTSTANDING));
    accept   = issue && (mem2q_response != 4'd0);
    // Lookups use the pre-edge table, so a tag accepted this cycle cannot complete this cycle.
    comp_hit = (mem2q_tag != 4'd0) && valid_q[mem2q_tag];
    comp_bad = (mem2q_tag != 4'd0) && !valid_q[mem2q_tag];
    acc_dup  = accept && valid_q[mem2q_response];

    wr_entry.cmd  = proc2q_command;
    wr_entry.addr = proc2q_address;
    wr_entry.data = (proc2q_command == CMD_STORE) ? proc2q_data : '0;

    wr_ptr_d      = wr_ptr_q + PTR_W'(enq);
    rd_ptr_d      = rd_ptr_q + PTR_W'(accept);
    count_d       = count_q + CNT_W'(enq) - CNT_W'(accept);
    outstanding_d = outstanding_q + 4'(accept) - 4'(comp_hit);

    // Clear before set: a same-tag accept+complete leaves the new entry in place.
    valid_d   = valid_q;
    is_load_d = is_load_q;
    if (comp_hit) valid_d[mem2q_tag] = 1'b0;
    if (accept) begin
      valid_d[mem2q_response]   = 1'b1;
      is_load_d[mem2q_response] = (head.cmd == CMD_LOAD);
    end

    ld_valid_d = comp_hit && is_load_q[mem2q_tag];
    st_done_d  = comp_hit && !is_load_q[mem2q_tag];
    ld_data_d  = ld_valid_d ? mem2q_data : '0;
    error_d    = error_q | comp_bad | acc_dup;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      valid_q       <= '0;
      is_load_q     <= '0;
      ld_valid_q    <= 1'b0;
      ld_data_q     <= '0;
      st_done_q     <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      valid_q       <= valid_d;
      is_load_q     <= is_load_d;
      ld_valid_q    <= ld_valid_d;
      ld_data_q     <= ld_data_d;
      st_done_q     <= st_done_d;
      error_q       <= error_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q guards every read, so stale contents are never visible.
  always_ff @(posedge clock) begin
    if (!reset && enq) fifo_q[wr_ptr_q] <= wr_entry;
  end

  assign q2proc_ready    = (count_q != CNT_W'(DEPTH));
  assign q2mem_command   = issue ? head.cmd  : CMD_NONE;
  assign q2mem_address   = issue ? head.addr : '0;
  assign q2mem_data      = issue ? head.data : '0;
  assign q2proc_ld_valid = ld_valid_q;
  assign q2proc_ld_data  = ld_data_q;
  assign q2proc_st_done  = st_done_q;
  assign q2proc_error    = error_q;
endmodule

// File: tb/tb_mem_req_queue.sv
// Directed bench for mem_req_queue: expected accepts and completions go into queues,
// a negedge monitor pops and compares them whenever the DUT shows an accept or a pulse.
module tb_mem_req_queue;
  logic        clock, reset;
  logic [1:0]  proc2q_command;
  logic [63:0] proc2q_address, proc2q_data;
  logic        q2proc_ready;
  logic [1:0]  q2mem_command;
  logic [63:0] q2mem_address, q2mem_data;
  logic [3:0]  mem2q_response, mem2q_tag;
  logic [63:0] mem2q_data;
  logic        q2proc_ld_valid;
  logic [63:0] q2proc_ld_data;
  logic        q2proc_st_done, q2proc_error;

  mem_req_queue #(.DEPTH(4), .MAX_OUTSTANDING(2), .DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .clock(clock), .reset(reset),
    .proc2q_command(proc2q_command), .proc2q_address(proc2q_address), .proc2q_data(proc2q_data),
    .q2proc_ready(q2proc_ready),
    .q2mem_command(q2mem_command), .q2mem_address(q2mem_address), .q2mem_data(q2mem_data),
    .mem2q_response(mem2q_response), .mem2q_tag(mem2q_tag), .mem2q_data(mem2q_data),
    .q2proc_ld_valid(q2proc_ld_valid), .q2proc_ld_data(q2proc_ld_data),
    .q2proc_st_done(q2proc_st_done), .q2proc_error(q2proc_error)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [63:0] data;
  } iss_t;

  iss_t        exp_iss[$];
  logic [63:0] exp_ld[$];
  int          exp_st;
  int          checks = 0;
  int          errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    proc2q_command = 2'd0; proc2q_address = '0; proc2q_data = '0;
    mem2q_response = 4'd0; mem2q_tag = 4'd0; mem2q_data = '0;
  endtask

  task automatic enq(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d);
    proc2q_command = c; proc2q_address = a; proc2q_data = d;
  endtask

  task automatic push_iss(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d);
    iss_t e;
    e.cmd = c; e.addr = a; e.data = d;
    exp_iss.push_back(e);
  endtask

  // Monitor: accepted issues and completion pulses are compared against the queues.
  always @(negedge clock) begin : mon
    iss_t e;
    if (reset === 1'b0) begin
      if (q2mem_command != 2'd0 && mem2q_response != 4'd0) begin
        if (exp_iss.size() == 0) check("accept_unexpected", {62'd0, q2mem_command}, 64'd0);
        else begin
          e = exp_iss.pop_front();
          check("acc_cmd", {62'd0, q2mem_command}, {62'd0, e.cmd});
          check("acc_addr", q2mem_address, e.addr);
          check("acc_data", q2mem_data, e.data);
        end
      end
      if (q2proc_ld_valid) begin
        if (exp_ld.size() == 0) check("ld_unexpected", 64'(q2proc_ld_valid), 64'd0);
        else check("ld_data", q2proc_ld_data, exp_ld.pop_front());
      end
      if (q2proc_st_done) begin
        if (exp_st == 0) check("st_unexpected", 64'(q2proc_st_done), 64'd0);
        else begin
          exp_st--;
          check("st_done", 64'(q2proc_st_done), 64'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_st = 0;
    reset = 1'b1;
    idle();
    cyc(); cyc();
    @(negedge clock);
    check("rst_cmd", {62'd0, q2mem_command}, 64'd0);
    check("rst_ready", 64'(q2proc_ready), 64'd1);
    check("rst_error", 64'(q2proc_error), 64'd0);
    check("rst_ld_valid", 64'(q2proc_ld_valid), 64'd0);
    cyc();

    // Test 1: single load, no pass-through, tag 3 completes two cycles after accept.
    reset = 1'b0;
    enq(2'd1, 64'h10, 64'h0);
    push_iss(2'd1, 64'h10, 64'h0);
    @(negedge clock);
    check("t1_no_bypass", {62'd0, q2mem_command}, 64'd0);
    cyc();
    idle(); mem2q_response = 4'd3;
    @(negedge clock);
    check("t1_issue_cmd", {62'd0, q2mem_command}, 64'd1);
    check("t1_issue_addr", q2mem_address, 64'h10);
    cyc();
    idle();
    @(negedge clock);
    check("t1_empty", {62'd0, q2mem_command}, 64'd0);
    cyc();
    mem2q_tag = 4'd3; mem2q_data = 64'hFFFF_0000_1234_5678;
    exp_ld.push_back(64'hFFFF_0000_1234_5678);
    @(negedge clock);
    check("t1_ld_not_yet", 64'(q2proc_ld_valid), 64'd0);
    cyc();
    idle();
    @(negedge clock);
    check("t1_ld_pulse", 64'(q2proc_ld_valid), 64'd1);
    check("t1_no_st", 64'(q2proc_st_done), 64'd0);
    cyc();
    @(negedge clock);
    check("t1_ld_cleared", 64'(q2proc_ld_valid), 64'd0);

    // Test 2: fill with resp=0; 5th enqueue dropped; head re-presented unchanged.
    cyc();
    enq(2'd1, 64'h100, 64'h0);           push_iss(2'd1, 64'h100, 64'h0);
    cyc();
    enq(2'd2, 64'h108, 64'hDEAD_BEEF);   push_iss(2'd2, 64'h108, 64'hDEAD_BEEF);
    @(negedge clock);
    check("t2_ready_1", 64'(q2proc_ready), 64'd1);
    check("t2_head_a", q2mem_address, 64'h100);
    cyc();
    enq(2'd1, 64'h110, 64'h0);           push_iss(2'd1, 64'h110, 64'h0);
    cyc();
    enq(2'd1, 64'h118, 64'h0);           push_iss(2'd1, 64'h118, 64'h0);
    @(negedge clock);
    check("t2_ready_3", 64'(q2proc_ready), 64'd1);
    check("t2_head_b", q2mem_address, 64'h100);
    cyc();
    enq(2'd2, 64'h120, 64'h55);
    @(negedge clock);
    check("t2_full_ready", 64'(q2proc_ready), 64'd0);
    check("t2_head_cmd", {62'd0, q2mem_command}, 64'd1);
    check("t2_head_c", q2mem_address, 64'h100);
    cyc();
    idle();
    @(negedge clock);
    check("t2_still_full", 64'(q2proc_ready), 64'd0);

    // Test 3: two accepted hit the outstanding limit; third waits for tag 1.
    mem2q_response = 4'd1;
    cyc();
    mem2q_response = 4'd2;
    @(negedge clock);
    check("t3_store_issue", {62'd0, q2mem_command}, 64'd2);
    cyc();
    mem2q_response = 4'd7;
    @(negedge clock);
    check("t3_limit_none", {62'd0, q2mem_command}, 64'd0);
    check("t3_limit_addr", q2mem_address, 64'd0);
    cyc();
    idle(); mem2q_tag = 4'd1; mem2q_data = 64'hAAAA_5555_0000_1111;
    exp_ld.push_back(64'hAAAA_5555_0000_1111);
    @(negedge clock);
    check("t3_still_none", {62'd0, q2mem_command}, 64'd0);
    cyc();
    idle();
    @(negedge clock);
    check("t3_third_cmd", {62'd0, q2mem_command}, 64'd1);
    check("t3_third_addr", q2mem_address, 64'h110);

    // Test 4: accept tag 5 while tag 2 (store) completes.
    mem2q_response = 4'd5; mem2q_tag = 4'd2;
    exp_st++;
    cyc();
    idle();
    @(negedge clock);
    check("t4_st_done", 64'(q2proc_st_done), 64'd1);
    check("t4_no_ld", 64'(q2proc_ld_valid), 64'd0);
    check("t4_next_issues", {62'd0, q2mem_command}, 64'd1);
    check("t4_next_addr", q2mem_address, 64'h118);
    mem2q_response = 4'd6;
    cyc();
    idle();
    @(negedge clock);
    check("t4_drained", {62'd0, q2mem_command}, 64'd0);
    check("t4_no_error", 64'(q2proc_error), 64'd0);
    mem2q_tag = 4'd5; mem2q_data = 64'h5555_0000_0000_0005;
    exp_ld.push_back(64'h5555_0000_0000_0005);
    cyc();
    mem2q_tag = 4'd6; mem2q_data = 64'h6666_0000_0000_0006;
    exp_ld.push_back(64'h6666_0000_0000_0006);
    cyc();
    idle();
    cyc();

    // Test 5: completion of an unknown tag is a sticky error with no pulses.
    mem2q_tag = 4'd9; mem2q_data = 64'h9;
    cyc();
    idle();
    @(negedge clock);
    check("t5_error", 64'(q2proc_error), 64'd1);
    check("t5_no_ld", 64'(q2proc_ld_valid), 64'd0);
    check("t5_no_st", 64'(q2proc_st_done), 64'd0);
    cyc(); cyc();
    @(negedge clock);
    check("t5_sticky", 64'(q2proc_error), 64'd1);

    // Test 6: reset with 2 queued and 2 outstanding, then a late completion.
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clock);
    check("t6_pre_error_clr", 64'(q2proc_error), 64'd0);
    enq(2'd1, 64'h200, 64'h0);           push_iss(2'd1, 64'h200, 64'h0);
    cyc();
    enq(2'd2, 64'h208, 64'h77);          push_iss(2'd2, 64'h208, 64'h77);
    mem2q_response = 4'd3;
    cyc();
    enq(2'd1, 64'h210, 64'h0);
    mem2q_response = 4'd4;
    cyc();
    enq(2'd1, 64'h218, 64'h0);
    mem2q_response = 4'd0;
    cyc();
    idle();
    @(negedge clock);
    check("t6_limit_none", {62'd0, q2mem_command}, 64'd0);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clock);
    check("t6_rst_cmd", {62'd0, q2mem_command}, 64'd0);
    check("t6_rst_addr", q2mem_address, 64'd0);
    check("t6_rst_data", q2mem_data, 64'd0);
    check("t6_rst_err", 64'(q2proc_error), 64'd0);
    check("t6_rst_ready", 64'(q2proc_ready), 64'd1);
    cyc();
    @(negedge clock);
    check("t6_queue_gone", {62'd0, q2mem_command}, 64'd0);
    mem2q_tag = 4'd3; mem2q_data = 64'h3;
    cyc();
    idle();
    @(negedge clock);
    check("t6_late_error", 64'(q2proc_error), 64'd1);
    check("t6_late_no_ld", 64'(q2proc_ld_valid), 64'd0);
    cyc(); cyc();

    check("iss_queue_empty", 64'(exp_iss.size()), 64'd0);
    check("ld_queue_empty", 64'(exp_ld.size()), 64'd0);
    check("st_count_zero", 64'(exp_st), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
